sound_sequencer: RTL and testbench
==================================

SOUND_SEQUENCER -- requirements
Module: sound_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000, clk cycles per duration tick (>=2).
REQ-002 SHALL have parameter DUR_BTN, default 50, play length in ticks for sound types 0 and 1.
REQ-003 SHALL have parameter DUR_SPEED, default 300, play length in ticks for sound type 2.
REQ-004 SHALL have parameter DUR_WIN, default 1000, play length in ticks for sound type 3.
REQ-005 SHALL have parameter GAP_TICKS, default 20, silent gap in ticks after each sound (>=1).
REQ-006 clk  input  1  system clock, all state on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 req  input  4  one-cycle request pulses; bit0 right push, bit1 left push, bit2 speed round, bit3 win game.
REQ-009 snd_type  output  2  sound type to the tone player (0 right, 1 left, 2 speed, 3 win).
REQ-010 snd_on  output  1  high while the tone player's audio is to be driven; low mutes.
REQ-011 busy  output  1  high in PLAY or GAP.
REQ-012 done  output  1  one-cycle pulse on the last cycle of each completed (non-preempted) PLAY.

Function
REQ-013 SHALL implement states IDLE, PLAY, GAP; all outputs registered.
REQ-014 Priority SHALL be win(3) > speed(2) > left(1) > right(0); multiple simultaneous bits resolve to the highest.
REQ-015 IDLE or GAP + any req: next cycle state=PLAY, snd_type=winner, snd_on=1 (1-cycle latency).
REQ-016 PLAY SHALL last exactly DUR_x*TICK_DIV cycles of snd_on=1; tick prescaler and duration counter restart at every PLAY entry.
REQ-017 PLAY expiry with no req: state=GAP, snd_on=0, done=1 for that cycle, snd_type held.
REQ-018 GAP SHALL last GAP_TICKS*TICK_DIV cycles, then IDLE; busy=0 in IDLE.
REQ-019 PLAY + req of strictly higher priority than current snd_type: preempt, restart PLAY with new type next cycle, no done pulse.
REQ-020 PLAY + req of equal/lower priority, not last cycle: handled per REQ-025/026.
REQ-021 req on the last PLAY cycle: accepted as new sound regardless of priority; straight to PLAY, GAP skipped, done still pulses.
REQ-022 Duration counter width SHALL be clog2 of largest DUR; prescaler width clog2(TICK_DIV); no wrap beyond terminal count.

Reset
REQ-023 rst SHALL force IDLE, snd_type=0, snd_on=0, busy=0, done=0, counters=0, pending cleared, asynchronously.
REQ-024 rst asserted mid-PLAY SHALL mute within same cycle edge (async); no done pulse; first req after release starts fresh per REQ-015.

Configuration
REQ-025 Macro SOUND_QUEUE_EN defined: one pending bit per type; non-preempting reqs during PLAY set pending; after GAP, highest pending played, its bit cleared; rst clears all.
REQ-026 Macro SOUND_QUEUE_EN undefined: non-preempting reqs during PLAY dropped; no pending storage synthesized.

Structure
REQ-027 Shared package sound_pkg SHALL hold sound type encodings (SND_RIGHT..SND_WIN), state enum, priority helper constant.
REQ-028 Sub-module tick_prescaler (clear input, tick output pulse every TICK_DIV cycles) SHALL be instantiated once.

Verification (TICK_DIV=4, DUR_BTN=2, DUR_SPEED=3, DUR_WIN=5, GAP_TICKS=1)
REQ-029 req=0001 in IDLE -> next cycle snd_type=0, snd_on=1 for 8 cycles, done on 8th, snd_on=0 4 cycles, busy low after.
REQ-030 req=0110 simultaneous -> snd_type=2, snd_on high 12 cycles.
REQ-031 req=0001, then req=1000 at cycle 3 -> snd_type=3 next cycle, 20 cycles snd_on, no done for type 0.
REQ-032 req=0100 then req=0001 at cycle 5: without SOUND_QUEUE_EN type 0 never plays; with it type 0 plays 8 cycles after the 4-cycle GAP.
REQ-033 req=0010 on last PLAY cycle -> done=1 and next cycle PLAY type 1, no GAP.
REQ-034 rst pulse at PLAY cycle 4 -> snd_on=0, busy=0 immediately, no done; req=0001 after release plays normally.

Source files
------------

// File: rtl/sound_pkg.sv
// Shared sound-sequencer types: sound type codes, FSM states and the request priority encoder.
package sound_pkg;

    localparam int unsigned NUM_SND = 4;

    typedef enum logic [1:0] {
        SND_RIGHT = 2'd0,
        SND_LEFT  = 2'd1,
        SND_SPEED = 2'd2,
        SND_WIN   = 2'd3
    } snd_type_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPlay = 2'd1,
        StGap  = 2'd2
    } state_e;

    // Higher encoding means higher priority, so SND_WIN always wins.
    localparam snd_type_e SND_TOP_PRIO = SND_WIN;

    function automatic snd_type_e prio_winner(input logic [NUM_SND-1:0] r);
        if (r[SND_WIN]) begin
            return SND_WIN;
        end else if (r[SND_SPEED]) begin
            return SND_SPEED;
        end else if (r[SND_LEFT]) begin
            return SND_LEFT;
        end
        return SND_RIGHT;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running clock divider producing a one-cycle tick every TICK_DIV cycles; clear_i restarts it.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    output logic tick_o,
    output logic pre_tick_o
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] cnt_q, cnt_d;

    // pre_tick_o flags the cycle before a tick so callers can register end-of-period outputs.
    assign tick_o     = (cnt_q == PW'(TICK_DIV - 1));
    assign pre_tick_o = (cnt_q == PW'(TICK_DIV - 2));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sound_sequencer.sv
// Prioritised sound request sequencer (IDLE/PLAY/GAP) with registered outputs.
// Define SOUND_QUEUE_EN to latch non-preempting requests and play them after the gap.
module sound_sequencer
    import sound_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 100000,
    parameter int unsigned DUR_BTN   = 50,
    parameter int unsigned DUR_SPEED = 300,
    parameter int unsigned DUR_WIN   = 1000,
    parameter int unsigned GAP_TICKS = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SND-1:0] req_i,
    output logic [1:0]         snd_type_o,
    output logic               snd_on_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam int unsigned MAX_BS  = (DUR_BTN > DUR_SPEED) ? DUR_BTN : DUR_SPEED;
    localparam int unsigned MAX_BSW = (MAX_BS > DUR_WIN) ? MAX_BS : DUR_WIN;
    localparam int unsigned DUR_MAX = (MAX_BSW > GAP_TICKS) ? MAX_BSW : GAP_TICKS;
    localparam int unsigned DUR_W   = (DUR_MAX > 1) ? $clog2(DUR_MAX) : 1;
    localparam logic [DUR_W-1:0] GAP_LAST = DUR_W'(GAP_TICKS - 1);

    state_e            state_q, state_d;
    snd_type_e         type_q, type_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic              snd_on_q, snd_on_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              clr;
    logic              tick;
    logic              pre_tick;
    logic              req_any;
    snd_type_e         req_win;
    logic              start;
    snd_type_e         start_type;
    logic [DUR_W-1:0]  dur_last;

`ifdef SOUND_QUEUE_EN
    logic [NUM_SND-1:0] pend_q, pend_d;
`endif

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_prescaler (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (clr),
        .tick_o     (tick),
        .pre_tick_o (pre_tick)
    );

    assign req_any = |req_i;
    assign req_win = prio_winner(req_i);

    always_comb begin
        unique case (type_q)
            SND_SPEED: dur_last = DUR_W'(DUR_SPEED - 1);
            SND_WIN:   dur_last = DUR_W'(DUR_WIN - 1);
            default:   dur_last = DUR_W'(DUR_BTN - 1);
        endcase
    end

    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        dur_d      = dur_q;
        done_d     = 1'b0;
        clr        = 1'b0;
        start      = 1'b0;
        start_type = req_win;
`ifdef SOUND_QUEUE_EN
        pend_d     = pend_q;
`endif
        unique case (state_q)
            StIdle: begin
                start = req_any;
            end
            StPlay: begin
                if (done_q) begin
                    // Last play cycle: any request is taken as a fresh sound, skipping the gap.
                    if (req_any) begin
                        start = 1'b1;
                    end else begin
                        state_d = StGap;
                        clr     = 1'b1;
                        dur_d   = '0;
                    end
                end else if (req_any && (req_win > type_q)) begin
                    start = 1'b1;
                end else begin
                    if (tick) begin
                        dur_d = dur_q + 1'b1;
                    end
                    done_d = pre_tick && (dur_q == dur_last);
`ifdef SOUND_QUEUE_EN
                    pend_d = pend_q | req_i;
`endif
                end
            end
            StGap: begin
                if (req_any) begin
                    start = 1'b1;
                end else if (tick && (dur_q == GAP_LAST)) begin
                    state_d = StIdle;
`ifdef SOUND_QUEUE_EN
                    if (|pend_q) begin
                        start      = 1'b1;
                        start_type = prio_winner(pend_q);
                        pend_d     = pend_q & ~(NUM_SND'(1) << prio_winner(pend_q));
                    end
`endif
                end else if (tick) begin
                    dur_d = dur_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Every PLAY entry restarts the prescaler and the duration count.
        if (start) begin
            state_d = StPlay;
            type_d  = start_type;
            clr     = 1'b1;
            dur_d   = '0;
            done_d  = 1'b0;
        end

        snd_on_d = (state_d == StPlay);
        busy_d   = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            type_q   <= SND_RIGHT;
            dur_q    <= '0;
            snd_on_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            type_q   <= type_d;
            dur_q    <= dur_d;
            snd_on_q <= snd_on_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

`ifdef SOUND_QUEUE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end
`endif

    assign snd_type_o = type_q;
    assign snd_on_o   = snd_on_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed self-checking bench for sound_sequencer with small tick/duration parameters.
module tb_sound_sequencer;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [1:0] snd_type;
    logic       snd_on;
    logic       busy;
    logic       done;
    logic [4:0] obs;

    int checks;
    int errors;

    sound_sequencer #(
        .TICK_DIV  (4),
        .DUR_BTN   (2),
        .DUR_SPEED (3),
        .DUR_WIN   (5),
        .GAP_TICKS (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req),
        .snd_type_o (snd_type),
        .snd_on_o   (snd_on),
        .busy_o     (busy),
        .done_o     (done)
    );

    // Observation vector: {snd_on, busy, done, snd_type}
    assign obs = {snd_on, busy, done, snd_type};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b0000;
        repeat (3) @(negedge clk);
        checks++;
        if (obs !== 5'b00000) begin
            errors++;
            $display("FAIL reset_state: got %b want %b", obs, 5'b00000);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== 5'b00000) begin
            errors++;
            $display("FAIL idle_after_reset: got %b want %b", obs, 5'b00000);
        end
    endtask

    // Right push: 8 play cycles, done on the 8th, 4 gap cycles, then idle.
    task automatic test_basic();
        logic [4:0] exp;
        req = 4'b0001;
        @(negedge clk);
        req = 4'b0000;
        for (int i = 1; i <= 8; i++) begin
            exp = {1'b1, 1'b1, (i == 8), 2'd0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL basic_play cyc %0d: got %b want %b", i, obs, exp);
            end
            @(negedge clk);
        end
        for (int i = 1; i <= 4; i++) begin
            exp = {1'b0, 1'b1, 1'b0, 2'd0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL basic_gap cyc %0d: got %b want %b", i, obs, exp);
            end
            @(negedge clk);
        end
        exp = {1'b0, 1'b0, 1'b0, 2'd0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL basic_idle: got %b want %b", obs, exp);
        end
    endtask

    // Speed + left together: speed wins, 12 play cycles.
    task automatic test_priority();
        logic [4:0] exp;
        req = 4'b0110;
        @(negedge clk);
        req = 4'b0000;
        for (int i = 1; i <= 12; i++) begin
            exp = {1'b1, 1'b1, (i == 12), 2'd2};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL prio_play cyc %0d: got %b want %b", i, obs, exp);
            end
            @(negedge clk);
        end
        for (int i = 1; i <= 4; i++) begin
            exp = {1'b0, 1'b1, 1'b0, 2'd2};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL prio_gap cyc %0d: got %b want %b", i, obs, exp);
            end
            @(negedge clk);
        end
        exp = {1'b0, 1'b0, 1'b0, 2'd2};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL prio_idle: got %b want %b", obs, exp);
        end
    endtask

    // Win request during a right-push play preempts it without a done pulse.
    task automatic test_preempt();
        logic [4:0] exp;
        req = 4'b0001;
        @(negedge clk);
        req = 4'b0000;
        for (int i = 1; i <= 3; i++) begin
            exp = {1'b1, 1'b1, 1'b0, 2'd0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL preempt_pre cyc %0d: got %b want %b", i, obs, exp);
            end
            if (i == 3) req = 4'b1000;
            @(negedge clk);
        end
        req = 4'b0000;
        for (int i = 1; i <= 20; i++) begin
            exp = {1'b1, 1'b1, (i == 20), 2'd3};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL preempt_win cyc %0d: got %b want %b", i, obs, exp);
            end
            @(negedge clk);
        end
        for (int i = 1; i <= 4; i++) begin
            exp = {1'b0, 1'b1, 1'b0, 2'd3};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL preempt_gap cyc %0d: got %b want %b", i, obs, exp);
            end
            @(negedge clk);
        end
    endtask

    // Lower-priority request during speed play: dropped, or queued when SOUND_QUEUE_EN.
    task automatic test_lower_req();
        logic [4:0] exp;
        req = 4'b0100;
        @(negedge clk);
        req = 4'b0000;
        for (int i = 1; i <= 12; i++) begin
            exp = {1'b1, 1'b1, (i == 12), 2'd2};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL lower_play cyc %0d: got %b want %b", i, obs, exp);
            end
            if (i == 5) req = 4'b0001;
            @(negedge clk);
            if (i == 5) req = 4'b0000;
        end
        for (int i = 1; i <= 4; i++) begin
            exp = {1'b0, 1'b1, 1'b0, 2'd2};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL lower_gap cyc %0d: got %b want %b", i, obs, exp);
            end
            @(negedge clk);
        end
`ifdef SOUND_QUEUE_EN
        for (int i = 1; i <= 8; i++) begin
            exp = {1'b1, 1'b1, (i == 8), 2'd0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL queued_play cyc %0d: got %b want %b", i, obs, exp);
            end
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        exp = {1'b0, 1'b0, 1'b0, 2'd0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL queued_idle: got %b want %b", obs, exp);
        end
`else
        for (int i = 1; i <= 10; i++) begin
            exp = {1'b0, 1'b0, 1'b0, 2'd2};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL dropped_idle cyc %0d: got %b want %b", i, obs, exp);
            end
            @(negedge clk);
        end
`endif
    endtask

    // Left request on the last play cycle: done pulses and left plays with no gap.
    task automatic test_back_to_back();
        logic [4:0] exp;
        req = 4'b0001;
        @(negedge clk);
        req = 4'b0000;
        for (int i = 1; i <= 8; i++) begin
            exp = {1'b1, 1'b1, (i == 8), 2'd0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL b2b_first cyc %0d: got %b want %b", i, obs, exp);
            end
            if (i == 8) req = 4'b0010;
            @(negedge clk);
        end
        req = 4'b0000;
        for (int i = 1; i <= 8; i++) begin
            exp = {1'b1, 1'b1, (i == 8), 2'd1};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL b2b_second cyc %0d: got %b want %b", i, obs, exp);
            end
            @(negedge clk);
        end
        for (int i = 1; i <= 4; i++) begin
            exp = {1'b0, 1'b1, 1'b0, 2'd1};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL b2b_gap cyc %0d: got %b want %b", i, obs, exp);
            end
            @(negedge clk);
        end
        exp = {1'b0, 1'b0, 1'b0, 2'd1};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL b2b_idle: got %b want %b", obs, exp);
        end
    endtask

    // Asynchronous reset mid-play mutes at once; a later request plays normally.
    task automatic test_reset_mid_play();
        logic [4:0] exp;
        req = 4'b0001;
        @(negedge clk);
        req = 4'b0000;
        for (int i = 1; i <= 4; i++) begin
            exp = {1'b1, 1'b1, 1'b0, 2'd0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL rstmid_play cyc %0d: got %b want %b", i, obs, exp);
            end
            if (i < 4) @(negedge clk);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== 5'b00000) begin
            errors++;
            $display("FAIL rstmid_async: got %b want %b", obs, 5'b00000);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== 5'b00000) begin
            errors++;
            $display("FAIL rstmid_after: got %b want %b", obs, 5'b00000);
        end
        test_basic();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        req    = 4'b0000;
        test_reset();
        test_basic();
        test_priority();
        test_preempt();
        test_lower_req();
        test_back_to_back();
        test_reset_mid_play();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
